// File: rtl/seg7_pkg.sv
// Shared constants, FSM encoding and width helpers for the 7-segment scan controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package seg7_pkg;

   // All segments dark (active-low)
   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Active-low segment patterns for 0..F, bit0=a ... bit6=g
   localparam logic [6:0] SEG_TAB [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef enum logic {
      S_BLANK = 1'b0,
      S_ON    = 1'b1
   } state_t;

   // Bits needed to hold 0..n-1, never less than one bit
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/hex7seg_dec.sv
// Hex nibble to active-low 7-segment pattern decoder.
// Latency: combinational, 0 cycles.
// Backpressure: none, pure function of the input nibble.
module hex7seg_dec
   import seg7_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg_n
);

   assign seg_n = SEG_TAB[hex];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan of a common-anode 7-segment bank with a double-buffered frame.
// Latency: pins are registered, 1 cycle behind the scan state; staged data commits at frame end.
// Backpressure: load_ready drops while a staged frame waits for the frame boundary.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS   = 8,
   parameter int ON_CYCLES    = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load_valid,
   input  logic [4*NUM_DIGITS-1:0] load_data,
   output logic                    load_ready,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic                    lz_suppress,
   output logic [6:0]              seg_n,
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic                    frame_commit
);

   localparam int CW = cnt_w((ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES);
   localparam int IW = cnt_w(NUM_DIGITS);
   localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   state_t                  state, state_nxt;
   logic [CW-1:0]           cnt, cnt_nxt;
   logic [IW-1:0]           idx, idx_nxt;
   logic                    frame_end;
   logic [4*NUM_DIGITS-1:0] disp, stage;
   logic                    pending;
   logic [3:0]              cur_nib;
   logic                    cur_vis;
   logic [6:0]              dec_seg;

   hex7seg_dec u_dec (
      .hex   (cur_nib),
      .seg_n (dec_seg)
   );

   // Scan state, slot counter and digit index
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_BLANK;
         cnt   <= '0;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
      end
   end

   // Blank gap then on-time per digit; frame ends on the last ON cycle of the top digit
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 1'b1;
      idx_nxt   = idx;
      frame_end = 1'b0;
      case (state)
         S_BLANK: begin
            if (cnt == BLANK_LAST) begin
               state_nxt = S_ON;
               cnt_nxt   = '0;
            end
         end
         S_ON: begin
            if (cnt == ON_LAST) begin
               state_nxt = S_BLANK;
               cnt_nxt   = '0;
               if (idx == IDX_LAST) begin
                  idx_nxt   = '0;
                  frame_end = 1'b1;
               end else begin
                  idx_nxt = idx + 1'b1;
               end
            end
         end
         default: begin
            state_nxt = S_BLANK;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Select the current nibble and decide visibility; leading zeros scanned from the top down
   always_comb begin
      logic zero_up;
      cur_nib = 4'h0;
      cur_vis = 1'b0;
      zero_up = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_up = zero_up & (disp[4*i +: 4] == 4'h0);
         if (idx == IW'(i)) begin
            cur_nib = disp[4*i +: 4];
            cur_vis = digit_en[i] & ~(lz_suppress & (i != 0) & zero_up);
         end
      end
   end

   // Registered pin drive; hidden digits keep their slot but stay dark
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg_n <= SEG_OFF;
         an_n  <= '1;
      end else if (state == S_ON && cur_vis) begin
         seg_n <= dec_seg;
         an_n  <= ~(NUM_DIGITS'(1) << idx);
      end else begin
         seg_n <= SEG_OFF;
         an_n  <= '1;
      end
   end

   // Staging buffer accepts one frame; it moves to the display only at frame end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stage        <= '0;
         disp         <= '0;
         pending      <= 1'b0;
         frame_commit <= 1'b0;
      end else begin
         frame_commit <= 1'b0;
         if (frame_end && pending) begin
            disp         <= stage;
            pending      <= 1'b0;
            frame_commit <= 1'b1;
         end else if (load_valid && !pending) begin
            stage   <= load_data;
            pending <= 1'b1;
         end
      end
   end

   assign load_ready = ~pending;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl with 8 digits, 4 on-cycles and 2 blank cycles.
// Latency: expected lit runs and commit cycles are queued ahead and matched as they appear.
// Backpressure: load_ready is checked around each accepted and refused transfer.
module tb_seg7_scan_ctrl;

   localparam int N     = 8;
   localparam int ON    = 4;
   localparam int BL    = 2;
   localparam int SLOT  = ON + BL;
   localparam int FRAME = N * SLOT;

   localparam logic [31:0] DAT_A = 32'h0000_0123;
   localparam logic [31:0] DAT_B = 32'h89AB_CDEF;

   typedef struct {
      logic [7:0] an;
      logic [6:0] seg;
      int         start;
      int         len;
   } evt_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load_valid = 1'b0;
   logic [31:0] load_data = '0;
   logic        load_ready;
   logic [7:0]  digit_en = 8'hFF;
   logic        lz_suppress = 1'b0;
   logic [6:0]  seg_n;
   logic [7:0]  an_n;
   logic        frame_commit;

   int   tick = 0;
   int   base = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   bit   mon_en = 1'b0;
   evt_t exp_q[$];
   int   commit_q[$];

   seg7_scan_ctrl #(
      .NUM_DIGITS   (N),
      .ON_CYCLES    (ON),
      .BLANK_CYCLES (BL)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_valid   (load_valid),
      .load_data    (load_data),
      .load_ready   (load_ready),
      .digit_en     (digit_en),
      .lz_suppress  (lz_suppress),
      .seg_n        (seg_n),
      .an_n         (an_n),
      .frame_commit (frame_commit)
   );

   always #5 clk = ~clk;

   always @(posedge clk) tick++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (tick %0d)", tag, got, exp, tick);
      end
   endtask

   function automatic logic [6:0] seg_of(input logic [3:0] h);
      case (h)
         4'h0: return 7'h40;
         4'h1: return 7'h79;
         4'h2: return 7'h24;
         4'h3: return 7'h30;
         4'h4: return 7'h19;
         4'h5: return 7'h12;
         4'h6: return 7'h02;
         4'h7: return 7'h78;
         4'h8: return 7'h00;
         4'h9: return 7'h10;
         4'hA: return 7'h08;
         4'hB: return 7'h03;
         4'hC: return 7'h46;
         4'hD: return 7'h21;
         4'hE: return 7'h06;
         default: return 7'h0E;
      endcase
   endfunction

   // Queue the lit runs expected in frame f of the current timeline (digits 0..ndig-1)
   task automatic push_frame(input int f, input logic [31:0] d, input bit lz,
                             input logic [7:0] en, input int ndig);
      bit   supp;
      evt_t e;
      for (int i = 0; i < ndig; i++) begin
         supp = lz && (i != 0) && ((d >> (4 * i)) == 32'h0);
         if (en[i] && !supp) begin
            e.an    = ~(8'h01 << i);
            e.seg   = seg_of(d[4*i +: 4]);
            e.start = base + f * FRAME + i * SLOT + BL + 1;
            e.len   = ON;
            exp_q.push_back(e);
         end
      end
   endtask

   // Advance to the negedge following cycle k of the current timeline
   task automatic go_to(input int k);
      while (tick < base + k) @(negedge clk);
   endtask

   logic [7:0] pr_an;
   logic [6:0] pr_seg;
   bit         pr_lit = 1'b0;
   bit         m_lit;
   int         r_start = 0;
   int         r_len = 0;
   evt_t       m_e;

   // Collapse pin activity into lit runs and match them, and commit pulses, against the queues
   always @(posedge clk) begin
      #1;
      if (mon_en) begin
         m_lit = (an_n !== 8'hFF);
         if (!m_lit) chk("dark_seg", seg_n, 7'h7F);
         if (pr_lit && (!m_lit || an_n !== pr_an || seg_n !== pr_seg)) begin
            if (exp_q.size() == 0) begin
               chk("evt_extra", pr_an, 8'hFF);
            end else begin
               m_e = exp_q.pop_front();
               chk("evt_an", pr_an, m_e.an);
               chk("evt_seg", pr_seg, m_e.seg);
               chk("evt_start", r_start, m_e.start);
               chk("evt_len", r_len, m_e.len);
            end
         end
         if (m_lit && !(pr_lit && an_n === pr_an && seg_n === pr_seg)) begin
            r_start = tick;
            r_len   = 1;
         end else if (m_lit) begin
            r_len++;
         end
         pr_lit = m_lit;
         pr_an  = an_n;
         pr_seg = seg_n;
         if (frame_commit !== 1'b0) begin
            if (commit_q.size() == 0) chk("commit_extra", frame_commit, 1'b0);
            else chk("commit_cycle", tick, commit_q.pop_front());
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      evt_t e;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_seg", seg_n, 7'h7F);
      chk("rst_an", an_n, 8'hFF);
      chk("rst_ready", load_ready, 1'b1);
      chk("rst_commit", frame_commit, 1'b0);
      mon_en = 1'b1;
      rst_n  = 1'b1;
      base   = tick;

      // Frame 0 shows reset data; A is offered, then B is held while not ready
      push_frame(0, 32'h0, 1'b0, 8'hFF, N);
      go_to(2);
      load_valid = 1'b1;
      load_data  = DAT_A;
      commit_q.push_back(base + FRAME);
      go_to(3);
      chk("ready_fall", load_ready, 1'b0);
      load_data = DAT_B;
      go_to(47);
      chk("ready_pending", load_ready, 1'b0);
      go_to(48);
      chk("ready_rise", load_ready, 1'b1);
      push_frame(1, DAT_A, 1'b0, 8'hFF, N);
      go_to(49);
      chk("ready_b_acc", load_ready, 1'b0);
      load_valid = 1'b0;
      commit_q.push_back(base + 2 * FRAME);

      // Frame 2 shows B; A is loaded again for frame 3
      go_to(96);
      push_frame(2, DAT_B, 1'b0, 8'hFF, N);
      load_valid = 1'b1;
      load_data  = DAT_A;
      commit_q.push_back(base + 3 * FRAME);
      go_to(97);
      chk("ready_a2", load_ready, 1'b0);
      load_valid = 1'b0;

      // Frame 3 with leading-zero suppression; zero frame accepted on the frame-end cycle
      go_to(144);
      lz_suppress = 1'b1;
      push_frame(3, DAT_A, 1'b1, 8'hFF, N);
      go_to(191);
      load_valid = 1'b1;
      load_data  = 32'h0;
      go_to(192);
      chk("ready_fe_acc", load_ready, 1'b0);
      load_valid = 1'b0;
      commit_q.push_back(base + 5 * FRAME);
      push_frame(4, DAT_A, 1'b1, 8'hFF, N);
      go_to(240);
      push_frame(5, 32'h0, 1'b1, 8'hFF, N);

      // Frame 6 with digit 0 disabled; slot timing must not move
      go_to(288);
      lz_suppress = 1'b0;
      digit_en    = 8'hFE;
      push_frame(6, 32'h0, 1'b0, 8'hFE, N);

      // Frame 7 is cut by reset during digit 5 with a frame still pending
      go_to(336);
      digit_en = 8'hFF;
      push_frame(7, 32'h0, 1'b0, 8'hFF, 5);
      e.an    = 8'hDF;
      e.seg   = 7'h40;
      e.start = base + 7 * FRAME + 5 * SLOT + BL + 1;
      e.len   = 1;
      exp_q.push_back(e);
      go_to(338);
      load_valid = 1'b1;
      load_data  = 32'hFFFF_FFFF;
      go_to(339);
      load_valid = 1'b0;
      chk("ready_d", load_ready, 1'b0);
      go_to(369);
      rst_n = 1'b0;
      go_to(370);
      chk("mid_rst_seg", seg_n, 7'h7F);
      chk("mid_rst_an", an_n, 8'hFF);
      chk("mid_rst_ready", load_ready, 1'b1);
      chk("mid_rst_commit", frame_commit, 1'b0);
      rst_n = 1'b1;
      base  = tick;
      push_frame(0, 32'h0, 1'b0, 8'hFF, N);
      go_to(52);

      chk("evt_left", exp_q.size(), 0);
      chk("commit_left", commit_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for the board's common-anode 7-segment bank. It shares one hex-to-7-segment decoder across `NUM_DIGITS` digits, stepping through them with a programmable on-time and an anti-ghosting blank gap. Display data is double-buffered: a new frame is accepted through a valid/ready handshake and committed only at a frame boundary, so partial updates never appear. It sits between the core logic, which supplies nibble data, and the segment/anode pins.

## Interface
- `NUM_DIGITS`, 8: digits scanned; 2..8.
- `ON_CYCLES`, 50000: cycles each digit is lit; ≥1.
- `BLANK_CYCLES`, 500: all-off cycles before each digit; ≥1.
- `clk` in 1: system clock.
- `rst_n` in 1: reset; synchronous, active-low.
- `load_valid` in 1: new display data offered.
- `load_data` in 4*NUM_DIGITS: nibble i = digit i; digit 0 is rightmost.
- `load_ready` out 1: staging buffer free.
- `digit_en` in NUM_DIGITS: per-digit enable; 0 = digit kept dark in its slot.
- `lz_suppress` in 1: blank leading zero digits.
- `seg_n` out 7: active-low segments, bit0=a … bit6=g.
- `an_n` out NUM_DIGITS: active-low digit selects.
- `frame_commit` out 1: 1-cycle pulse when staged data becomes displayed.

## Operation
- Reset values: `seg_n`=7'h7F; `an_n`=all ones; `load_ready`=1; `frame_commit`=0; display and staging registers=0; digit index=0; FSM=BLANK with counter=0.
- FSM: BLANK (count `BLANK_CYCLES`) → ON (count `ON_CYCLES`) → BLANK for the next digit.
  - Index runs 0→NUM_DIGITS-1 and then wraps to 0.
  - The frame ends on the last cycle of ON for digit NUM_DIGITS-1.
- BLANK: `an_n` all ones and `seg_n`=7'h7F.
- ON for digit i:
  - If the digit is visible: `an_n[i]`=0, all other anodes 1, and `seg_n`=decode(disp[i]).
  - If it is not visible: `an_n` all ones and `seg_n`=7'h7F.
  - Slot timing is identical either way.
- Visible(i) = `digit_en[i]` AND NOT suppressed(i).
  - suppressed(i) requires all three: `lz_suppress`=1, i≠0, and disp[j]==0 for every j≥i.
- Decoder covers 0–F; `seg_n` for 0 is 7'h40, 1 is 7'h79, 8 is 7'h00, 9 is 7'h10, A is 7'h08, F is 7'h0E.
- Handshake:
  - `load_ready` = NOT pending.
  - On `load_valid`&`load_ready`: staging ← `load_data` and pending ← 1.
  - At frame end with pending=1: disp ← staging, pending ← 0, and `frame_commit` pulses.
  - A transfer accepted in the frame-end cycle itself is committed at the next frame end, not the current one.
  - `load_valid` while not ready is ignored; data is not captured.
- `digit_en` and `lz_suppress` are live: they are sampled every cycle, not buffered.
- Reset mid-frame aborts the scan; the next frame starts from digit 0 BLANK and pending data is discarded.

## Timing
- All outputs are registered, with 1 cycle latency from FSM state to pins.
- After the first clock with `rst_n`=1:
  - Digit 0 is lit on pins from cycle BLANK_CYCLES+1 through BLANK_CYCLES+ON_CYCLES.
  - Frame period = NUM_DIGITS*(BLANK_CYCLES+ON_CYCLES) cycles.
- `frame_commit` is asserted on the same cycle the new disp value is visible to the FSM. The pins reflect it starting at digit 0's ON of the next frame.
- `load_ready` falls the cycle after acceptance and rises the cycle after commit.
- Counters are sized with $clog2 of their maximum values and must not overflow at the parameter maxima.

## Structure
- Package `seg7_pkg`:
  - Segment constants SEG_OFF=7'h7F and the 0–F segment table.
  - FSM enum {S_BLANK, S_ON}.
  - Width helpers.
- One sub-module, `hex7seg_dec`: a combinational 4→7 active-low decoder built from the package table and instantiated once.
- Top level holds the FSM, the cycle counter, the digit index, the staging/display registers, and the suppression logic.

## Test plan
- Reset, then load 32'h0000_0123 with NUM_DIGITS=8, ON=4, BLANK=2, lz_suppress=0, enables all set → digits 0..7 show seg_n 7'h30, 7'h24, 7'h79, then 7'h40 ×5, each lit for exactly 4 cycles after a 2-cycle dark gap.
- Same data with lz_suppress=1 → digits 3–7 stay dark while their slots still take 6 cycles each; 32'h0 shows only digit 0 as 7'h40.
- Handshake:
  - Load A, then hold `load_valid` with B while `load_ready`=0 → B is not captured; A commits at frame end with one `frame_commit` pulse.
  - `load_ready` returns to 1 afterwards; B is then accepted.
- Accept data exactly on the frame-end cycle → no commit that frame; the commit comes at the next frame end.
- `digit_en`=8'b1111_1110 → digit 0 is dark for its slot and the frame period is unchanged (48 cycles).
- Drop `rst_n` for 1 cycle mid-digit-5 → the cycle after reset, outputs are 7'h7F / all ones, `load_ready`=1, and the scan restarts at digit 0 per the reset timing.
